fp_mul_pipe: RTL and testbench
==============================

// Module: fp_mul_pipe
// PURPOSE
//  Parametrised, pipelined floating-point multiplier for the custom {sign, exp, frac} format.
//  Format: sign bit, biased exponent, fraction with a hidden leading 1.
//  Successor to the fixed 7/16 sign/adder/multiplier/normaliser chain; adds round-to-nearest-even,
//  zero handling, saturation, valid/ready flow control and a sideband tag.
//  Sits between operand fetch and the accumulator/result writeback in the datapath.
// PARAMETERS
//  EXP_W   7                    exponent width
//  FRAC_W  16                   fraction width (hidden 1 not stored)
//  BIAS    2**(EXP_W-1)-1       exponent offset (63 at default)
//  TAG_W   4                    sideband tag width, passed through unchanged
//  (derived) DW = 1+EXP_W+FRAC_W; operand word = {sign, exp[EXP_W-1:0], frac[FRAC_W-1:0]}
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      synchronous reset, active-high
//  in_valid      in   1      operand pair valid
//  in_ready      out  1      block accepts operands this cycle
//  in_a          in   DW     operand A
//  in_b          in   DW     operand B
//  in_tag        in   TAG_W  sideband tag for this pair
//  out_valid     out  1      result valid
//  out_ready     in   1      downstream accepts result
//  out_p         out  DW     product
//  out_tag       out  TAG_W  tag of this product
//  out_overflow  out  1      result saturated
//  out_underflow out  1      result flushed to zero by exponent underflow
//  out_inexact   out  1      rounding discarded nonzero bits, or saturation/flush occurred
// BEHAVIOUR
//  Encoding: exp==0 is zero (frac ignored); no inf/NaN; exp all-ones is a normal value.
//  Pipeline: 3 stages, per-stage valid bit; latency 3 cycles from accept to out_valid with no stall.
//   S1: sign = sa^sb; mant product {1,fa}*{1,fb} (2*FRAC_W+2 bits); esum = ea+eb-BIAS, signed, EXP_W+2 bits;
//       zero flag = (ea==0)|(eb==0).
//   S2: normalise: if product MSB set, shift right 1 and esum+1. Keep FRAC_W bits plus guard bit
//       and sticky (OR of the rest). RNE: increment if guard & (sticky | lsb).
//       Rounding carry out of frac sets frac=0 and esum+1.
//   S3: pack and classify; priority zero > overflow > underflow > normal:
//       zero      -> {sign,0,0}, no flags.
//       esum > 2**EXP_W-1 -> {sign, all-ones, all-ones}, overflow=1, inexact=1.
//       esum < 1  -> {sign,0,0}, underflow=1, inexact=1.
//       normal    -> {sign, esum[EXP_W-1:0], frac}, inexact = guard|sticky.
//  Flow control: advance = ~out_valid | out_ready. All stages shift only when advance=1.
//   in_ready = advance (combinational). A pair is accepted on in_valid & in_ready.
//   Bubbles propagate as invalid stages and are not compressed.
//  While out_valid & ~out_ready: out_p, out_tag and all flags hold stable; no input is accepted.
//  Flags and tag are qualified by out_valid and belong to the same transaction as out_p.
//  Reset: all stage valids 0, out_valid=0, out_p=0, out_tag=0, all flags 0, in_ready=1 during and after.
//   In-flight data is discarded on reset mid-operation.
//  Full throughput: one result per cycle while out_ready=1.
// TESTING (defaults: EXP_W=7, FRAC_W=16, 1.0=24'h3F0000)
//  3F0000 x 3F0000 -> out_p=3F0000 exactly 3 cycles after accept; flags 0.
//  3F8000 x 3F8000 (1.5*1.5) -> 402000; BF0000 x 3F8000 -> BF8000 (sign).
//  3F0001 x 3F0001 -> 3F0002, inexact=1.
//  7F0000 x 7F0000 -> 7FFFFF, overflow=1. 810000 x 010000 -> 800000, underflow=1.
//  000000 x 3F8000 -> 000000, no flags.
//  Stream 8 pairs with tags 0..7; hold out_ready=0 for 5 cycles mid-stream -> in_ready=0, outputs held,
//   then all 8 results in order with matching tags, none lost or duplicated.
//  Assert rst with 2 pairs in flight -> next cycle out_valid=0; no stale result appears afterwards.

Source files
------------

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// The master side feeds operand pairs and consumes products; the multiplier is the slave.
interface fp_mul_pipe_if #(
   parameter int EXP_W  = 7,
   parameter int FRAC_W = 16,
   parameter int TAG_W  = 4
);
   localparam int DW = 1 + EXP_W + FRAC_W;

   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_a;
   logic [DW-1:0]    in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_p;
   logic [TAG_W-1:0] out_tag;
   logic             out_overflow;
   logic             out_underflow;
   logic             out_inexact;

   modport master (
      output in_valid, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_p, out_tag, out_overflow, out_underflow, out_inexact
   );

   modport slave (
      input  in_valid, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_p, out_tag, out_overflow, out_underflow, out_inexact
   );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage {sign, exp, frac} multiplier: mantissa product, normalise + round-to-nearest-even,
// then pack with zero/overflow/underflow classification. One shared advance enable stalls every stage.
module fp_mul_pipe #(
   parameter int EXP_W  = 7,
   parameter int FRAC_W = 16,
   parameter int BIAS   = 2**(EXP_W-1)-1,
   parameter int TAG_W  = 4
) (
   input logic          clk,
   input logic          rst,
   fp_mul_pipe_if.slave bus
);
   localparam int DW = 1 + EXP_W + FRAC_W;
   localparam int PW = 2*FRAC_W + 2;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] EXP_MAX = EW'((2**EXP_W) - 1);
   localparam logic signed [EW-1:0] EXP_MIN = EW'(1);

   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [FRAC_W-1:0] fa, fb;
   assign {sa, ea, fa} = bus.in_a;
   assign {sb, eb, fb} = bus.in_b;

   logic advance;
   logic out_valid_q;
   assign advance      = ~out_valid_q | bus.out_ready;
   assign bus.in_ready = advance;

   // Stage 1: sign, full mantissa product, biased exponent sum
   logic                    s1_valid_q, s1_sign_q, s1_zero_q;
   logic [PW-1:0]           s1_prod_q, s1_prod_d;
   logic signed [EW-1:0]    s1_esum_q, s1_esum_d;
   logic [TAG_W-1:0]        s1_tag_q;

   // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch can form.
   always_comb begin
      s1_prod_d = PW'({1'b1, fa}) * PW'({1'b1, fb});
      s1_esum_d = EW'(ea) + EW'(eb) - EW'(BIAS);
   end

   // Stage 2: normalise, then round to nearest even on guard/sticky
   logic                    s2_valid_q, s2_sign_q, s2_zero_q, s2_inexact_q;
   logic [FRAC_W-1:0]       s2_frac_q, s2_frac_d;
   logic signed [EW-1:0]    s2_esum_q, s2_esum_d;
   logic [TAG_W-1:0]        s2_tag_q;
   logic [PW-1:0]           norm;
   logic [FRAC_W-1:0]       frac_t;
   logic [FRAC_W:0]         frac_r;
   logic                    prod_msb, guard, sticky, round_up;

   always_comb begin
      prod_msb  = s1_prod_q[PW-1];
      norm      = prod_msb ? s1_prod_q : (s1_prod_q << 1);
      frac_t    = norm[PW-2 -: FRAC_W];
      guard     = norm[PW-2-FRAC_W];
      sticky    = |norm[PW-3-FRAC_W:0];
      round_up  = guard & (sticky | frac_t[0]);
      frac_r    = {1'b0, frac_t} + (FRAC_W+1)'(round_up);
      s2_frac_d = frac_r[FRAC_W-1:0];
      s2_esum_d = s1_esum_q + EW'(prod_msb) + EW'(frac_r[FRAC_W]);
   end

   // Stage 3: classify with priority zero > overflow > underflow > normal
   logic [DW-1:0]    out_p_q, out_p_d;
   logic [TAG_W-1:0] out_tag_q;
   logic             out_ovf_q, out_ovf_d;
   logic             out_unf_q, out_unf_d;
   logic             out_inx_q, out_inx_d;

   always_comb begin
      out_p_d   = {s2_sign_q, s2_esum_q[EXP_W-1:0], s2_frac_q};
      out_ovf_d = 1'b0;
      out_unf_d = 1'b0;
      out_inx_d = s2_inexact_q;
      if (s2_zero_q) begin
         out_p_d   = {s2_sign_q, {(DW-1){1'b0}}};
         out_inx_d = 1'b0;
      end else if (s2_esum_q > EXP_MAX) begin
         out_p_d   = {s2_sign_q, {(DW-1){1'b1}}};
         out_ovf_d = 1'b1;
         out_inx_d = 1'b1;
      end else if (s2_esum_q < EXP_MIN) begin
         out_p_d   = {s2_sign_q, {(DW-1){1'b0}}};
         out_unf_d = 1'b1;
         out_inx_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_p_q     <= '0;
         out_tag_q   <= '0;
         out_ovf_q   <= 1'b0;
         out_unf_q   <= 1'b0;
         out_inx_q   <= 1'b0;
      end else if (advance) begin
         s1_valid_q  <= bus.in_valid;
         s2_valid_q  <= s1_valid_q;
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            out_p_q   <= out_p_d;
            out_tag_q <= s2_tag_q;
            out_ovf_q <= out_ovf_d;
            out_unf_q <= out_unf_d;
            out_inx_q <= out_inx_d;
         end
      end
   end

   // NOTE: stage data registers are left unreset; their contents are ignored unless the stage valid is set.
   always_ff @(posedge clk) begin
      if (advance) begin
         s1_sign_q    <= sa ^ sb;
         s1_zero_q    <= (ea == '0) | (eb == '0);
         s1_prod_q    <= s1_prod_d;
         s1_esum_q    <= s1_esum_d;
         s1_tag_q     <= bus.in_tag;
         s2_sign_q    <= s1_sign_q;
         s2_zero_q    <= s1_zero_q;
         s2_frac_q    <= s2_frac_d;
         s2_esum_q    <= s2_esum_d;
         s2_inexact_q <= guard | sticky;
         s2_tag_q     <= s1_tag_q;
      end
   end

   assign bus.out_valid     = out_valid_q;
   assign bus.out_p         = out_p_q;
   assign bus.out_tag       = out_tag_q;
   assign bus.out_overflow  = out_ovf_q;
   assign bus.out_underflow = out_unf_q;
   assign bus.out_inexact   = out_inx_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed vector table, stall/reset sequences, and a random stream
// scored against an arithmetic reference model.
module tb_fp_mul_pipe;
   localparam int EXP_W  = 7;
   localparam int FRAC_W = 16;
   localparam int TAG_W  = 4;
   localparam int BIAS   = 63;
   localparam int EMAX   = (1 << EXP_W) - 1;

   typedef struct packed {
      logic [23:0] p;
      logic [3:0]  tag;
      logic        ovf;
      logic        unf;
      logic        inx;
   } res_t;

   typedef struct {
      logic [23:0] a;
      logic [23:0] b;
      logic [23:0] p;
      logic        ovf;
      logic        unf;
      logic        inx;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   fp_mul_pipe_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) bus ();

   fp_mul_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .BIAS(BIAS), .TAG_W(TAG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Value = 1.f * 2^(e-BIAS); multiply exactly, then round the integer mantissa by remainder comparison.
   function automatic res_t model(input logic [23:0] a, input logic [23:0] b, input logic [3:0] tag);
      res_t r;
      longint unsigned ma, mb, m, q, rem, half;
      int e, sh;
      r     = '0;
      r.tag = tag;
      r.p[23] = a[23] ^ b[23];
      if (a[22:16] == 0 || b[22:16] == 0) return r;
      ma = 64'(a[15:0]) + 64'd65536;
      mb = 64'(b[15:0]) + 64'd65536;
      m  = ma * mb;
      e  = int'(a[22:16]) + int'(b[22:16]) - BIAS;
      sh = 16;
      if (m >= (64'd1 << 33)) begin
         sh = 17;
         e++;
      end
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 17)) begin
         q = 64'd1 << 16;
         e++;
      end
      if (e > EMAX) begin
         r.p[22:0] = '1;
         r.ovf = 1'b1;
         r.inx = 1'b1;
      end else if (e < 1) begin
         r.unf = 1'b1;
         r.inx = 1'b1;
      end else begin
         r.p[22:16] = e[6:0];
         r.p[15:0]  = q[15:0];
         r.inx      = (rem != 0);
      end
      return r;
   endfunction

   function automatic logic [23:0] gen_operand();
      logic [23:0] v;
      v = 24'($urandom);
      case ($urandom_range(0, 7))
         0:       v[22:16] = 7'd0;
         1:       v[22:16] = 7'($urandom_range(0, 20));
         2:       v[22:16] = 7'($urandom_range(100, 127));
         default: v[22:16] = 7'($urandom_range(40, 86));
      endcase
      return v;
   endfunction

   function automatic res_t sample_out();
      res_t r;
      r.p   = bus.out_p;
      r.tag = bus.out_tag;
      r.ovf = bus.out_overflow;
      r.unf = bus.out_underflow;
      r.inx = bus.out_inexact;
      return r;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_a      = v.a;
      bus.in_b      = v.b;
      bus.in_tag    = idx[3:0];
      bus.out_ready = 1'b1;
      #1;
      check($sformatf("vec%0d in_ready", idx), 64'(bus.in_ready), 64'(1'b1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("vec%0d latency", idx), 64'(lat), 64'(3));
      check($sformatf("vec%0d out_p", idx), 64'(bus.out_p), 64'(v.p));
      check($sformatf("vec%0d tag", idx), 64'(bus.out_tag), 64'(idx[3:0]));
      check($sformatf("vec%0d flags", idx),
            64'({bus.out_overflow, bus.out_underflow, bus.out_inexact}),
            64'({v.ovf, v.unf, v.inx}));
   endtask

   // Streams n pairs; stall window forces out_ready low, rnd randomises both handshakes.
   task automatic run_stream(input string nm, input int n, input int stall_at, input int stall_len,
                             input bit rnd);
      res_t exp_q[$];
      res_t cur, prev, exp;
      bit   prev_stall = 1'b0;
      int   sent = 0, got = 0, cyc = 0;
      logic [23:0] a_cur, b_cur;
      a_cur = gen_operand();
      b_cur = gen_operand();
      prev  = '0;
      while (got < n && cyc < 4000) begin
         @(negedge clk);
         bus.in_valid = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
         bus.in_a     = a_cur;
         bus.in_b     = b_cur;
         bus.in_tag   = sent[3:0];
         if (rnd) bus.out_ready = ($urandom_range(0, 2) != 0);
         else     bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
         #1;
         cur = sample_out();
         if (prev_stall) begin
            check({nm, " hold valid"}, 64'(bus.out_valid), 64'(1'b1));
            check({nm, " hold data"}, 64'(cur), 64'(prev));
         end
         if (bus.out_valid && !bus.out_ready)
            check({nm, " in_ready in stall"}, 64'(bus.in_ready), 64'(1'b0));
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check({nm, " unexpected result"}, 64'(bus.out_valid), 64'(1'b0));
            end else begin
               exp = exp_q.pop_front();
               check($sformatf("%s result %0d", nm, got), 64'(cur), 64'(exp));
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(a_cur, b_cur, sent[3:0]));
            sent++;
            a_cur = gen_operand();
            b_cur = gen_operand();
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev       = cur;
         cyc++;
      end
      check({nm, " result count"}, 64'(got), 64'(n));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         #1;
         check({nm, " no extra result"}, 64'(bus.out_valid), 64'(1'b0));
      end
   endtask

   vec_t vecs[15];

   initial begin
      vecs[0]  = '{24'h3F0000, 24'h3F0000, 24'h3F0000, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{24'h3F8000, 24'h3F8000, 24'h402000, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{24'hBF0000, 24'h3F8000, 24'hBF8000, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{24'h3F0001, 24'h3F0001, 24'h3F0002, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{24'h7F0000, 24'h7F0000, 24'h7FFFFF, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{24'h810000, 24'h010000, 24'h800000, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{24'h000000, 24'h3F8000, 24'h000000, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{24'h800000, 24'h3F8000, 24'h800000, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{24'h3F0001, 24'h3F8000, 24'h3F8002, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{24'h3F0003, 24'h3F8000, 24'h3F8004, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{24'h3FFFFE, 24'h3F0001, 24'h400000, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{24'h7F0000, 24'h3F0000, 24'h7F0000, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{24'h010000, 24'h3F0000, 24'h010000, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{24'h010000, 24'h3E0000, 24'h000000, 1'b0, 1'b1, 1'b1};
      vecs[14] = '{24'h7F8000, 24'h3F8000, 24'h7FFFFF, 1'b1, 1'b0, 1'b1};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset out_valid", 64'(bus.out_valid), 64'(1'b0));
      check("reset out_p", 64'(bus.out_p), 64'(0));
      check("reset out_tag", 64'(bus.out_tag), 64'(0));
      check("reset flags", 64'({bus.out_overflow, bus.out_underflow, bus.out_inexact}), 64'(0));
      check("reset in_ready", 64'(bus.in_ready), 64'(1'b1));
      rst = 1'b0;

      for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

      run_stream("stall", 8, 5, 5, 1'b0);
      run_stream("random", 300, 0, 0, 1'b1);

      // Reset with two pairs in flight: nothing may emerge afterwards.
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_a      = 24'h3F8000;
      bus.in_b      = 24'h3F8000;
      bus.in_tag    = 4'hA;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_a      = 24'h400000;
      bus.in_tag    = 4'hB;
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      #1;
      check("in_ready during reset", 64'(bus.in_ready), 64'(1'b1));
      @(negedge clk);
      #1;
      check("post-reset out_valid", 64'(bus.out_valid), 64'(1'b0));
      check("post-reset in_ready", 64'(bus.in_ready), 64'(1'b1));
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         #1;
         check("no stale result", 64'(bus.out_valid), 64'(1'b0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
